regfile_sb: RTL and testbench

- Next-generation MIPS register file. Parametrised in data width, depth and number of read ports.
- Adds a write-through bypass, a per-register busy scoreboard for multi-cycle producers (loads, mult/div), and a busy-register counter.
- Keeps dedicated a0/v0 taps for the syscall/print path and adds a generic debug read port.
- Sits between decode (read ports, reservations) and writeback (write port).

---
 rtl/regfile_sb.sv | 111 +++++++++++
 tb/tb_regfile_sb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// MIPS register file with write-through bypass, per-register busy scoreboard
// and busy counter; register 0 is hardwired to zero.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        write_reg_number,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_reg,
  output logic [ADDR_W:0]          busy_count,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [DATA_W-1:0]        a0,
  output logic [DATA_W-1:0]        v0
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_count_q, busy_count_d;
  logic              wr_ok_s, rsv_ok_s, inc_s, dec_s;

  assign wr_ok_s  = WE && (write_reg_number != {ADDR_W{1'b0}});
  assign rsv_ok_s = rsv_en && (rsv_reg != {ADDR_W{1'b0}});

  // Register storage; index 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      regs_q[write_reg_number] <= write_data;
    end
  end

  // Per-register busy next state: a reservation beats a same-cycle write.
  always_comb begin
    busy_d = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < DEPTH; r++) begin
      if (rsv_ok_s && (rsv_reg == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_ok_s && (write_reg_number == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
  end

  // Incremental busy counter, clamped at both ends.
  always_comb begin
    inc_s = rsv_ok_s && !busy_q[rsv_reg];
    dec_s = wr_ok_s && busy_q[write_reg_number] &&
            !(rsv_ok_s && (rsv_reg == write_reg_number));
    busy_count_d = busy_count_q;
    case ({inc_s, dec_s})
      2'b10: begin
        if (busy_count_q != CNT_MAX) busy_count_d = busy_count_q + (ADDR_W+1)'(1);
        else busy_count_d = busy_count_q;
      end
      2'b01: begin
        if (busy_count_q != {(ADDR_W+1){1'b0}}) busy_count_d = busy_count_q - (ADDR_W+1)'(1);
        else busy_count_d = busy_count_q;
      end
      default: busy_count_d = busy_count_q;
    endcase
  end

  // Scoreboard state and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= {DEPTH{1'b0}};
      busy_count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] idx_s;
    assign idx_s = rd_addr[p*ADDR_W +: ADDR_W];

    // Read port p: forward in-flight write data when bypass is enabled.
    always_comb begin
      if ((BYPASS != 0) && wr_ok_s && (write_reg_number == idx_s)) begin
        rd_data[p*DATA_W +: DATA_W] = write_data;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = regs_q[idx_s];
      end
      rd_busy[p] = busy_q[idx_s];
    end
  end

  assign busy_count = busy_count_q;
  assign dbg_data   = regs_q[dbg_addr];
  assign a0         = regs_q[4];
  assign v0         = regs_q[2];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (bypass on/off) share stimulus
// and are checked against an array-based reference model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr = 10'd0;
  logic        WE = 1'b0;
  logic [4:0]  write_reg_number = 5'd0;
  logic [31:0] write_data = 32'd0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_reg = 5'd0;
  logic [4:0]  dbg_addr = 5'd0;

  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_busy, nb_rd_busy;
  logic [5:0]  busy_count, nb_busy_count;
  logic [31:0] dbg_data, a0, v0, nb_dbg_data, nb_a0, nb_v0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .WE(WE), .write_reg_number(write_reg_number), .write_data(write_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy_count(busy_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .a0(a0), .v0(v0));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .WE(WE), .write_reg_number(write_reg_number), .write_data(write_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .busy_count(nb_busy_count),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data), .a0(nb_a0), .v0(nb_v0));

  typedef struct {
    logic [31:0] d0, d1, n0, n1, dbg, a0, v0;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [32];
  bit          busy_m [32];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mem_m[i] = 32'd0;
      busy_m[i] = 1'b0;
    end
  endfunction

  function automatic logic [5:0] popcnt();
    logic [5:0] n = 6'd0;
    for (int i = 0; i < 32; i++) n += {5'd0, busy_m[i]};
    return n;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp, input logic we,
                                         input logic [4:0] wr, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (byp && we && wr == a) return wd;
    return mem_m[a];
  endfunction

  // One clock cycle of stimulus: drive, predict, then advance the model.
  task automatic cyc(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic rsv, input logic [4:0] rr,
                     input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dbg);
    exp_t e;
    @(negedge clk);
    WE = we; write_reg_number = wr; write_data = wd;
    rsv_en = rsv; rsv_reg = rr; rd_addr = {ra1, ra0}; dbg_addr = dbg;
    e.d0 = exp_rd(ra0, 1'b1, we, wr, wd);
    e.d1 = exp_rd(ra1, 1'b1, we, wr, wd);
    e.n0 = exp_rd(ra0, 1'b0, we, wr, wd);
    e.n1 = exp_rd(ra1, 1'b0, we, wr, wd);
    e.dbg = mem_m[dbg];
    e.a0 = mem_m[4];
    e.v0 = mem_m[2];
    e.busy = {busy_m[ra1], busy_m[ra0]};
    e.cnt = popcnt();
    q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (we && wr != 5'd0) mem_m[wr] = wd;
      if (rsv && rr != 5'd0) busy_m[rr] = 1'b1;
      if (we && wr != 5'd0 && !(rsv && rr == wr)) busy_m[wr] = 1'b0;
    end
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dbg);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1, dbg);
  endtask

  // Monitor: compares every pending expectation shortly after inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("rd_data0",    {32'd0, rd_data[31:0]},     {32'd0, e.d0});
        chk("rd_data1",    {32'd0, rd_data[63:32]},    {32'd0, e.d1});
        chk("nb_rd_data0", {32'd0, nb_rd_data[31:0]},  {32'd0, e.n0});
        chk("nb_rd_data1", {32'd0, nb_rd_data[63:32]}, {32'd0, e.n1});
        chk("dbg_data",    {32'd0, dbg_data},          {32'd0, e.dbg});
        chk("nb_dbg_data", {32'd0, nb_dbg_data},       {32'd0, e.dbg});
        chk("a0",          {32'd0, a0},                {32'd0, e.a0});
        chk("v0",          {32'd0, v0},                {32'd0, e.v0});
        chk("rd_busy",     {62'd0, rd_busy},           {62'd0, e.busy});
        chk("busy_count",  {58'd0, busy_count},        {58'd0, e.cnt});
        chk("nb_busy_count", {58'd0, nb_busy_count},   {58'd0, e.cnt});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    // Reset held: everything reads zero.
    idle(5'd4, 5'd2, 5'd4);
    #2 rst_n = 1'b1;

    // Write/read through both ports and the taps.
    cyc(1'b1, 5'd4, 32'hAAAA_BBBB, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 5'd2, 32'h1234_5678, 1'b0, 5'd0, 5'd4, 5'd2, 5'd4);
    idle(5'd4, 5'd2, 5'd2);

    // Bypass on reg 5, then stored value visible next cycle.
    cyc(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd5, 5'd5);
    idle(5'd5, 5'd4, 5'd5);

    // Zero register: write and reserve ignored.
    cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0, 5'd0);

    // Scoreboard sequence.
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8, 5'd9, 5'd8);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd8, 5'd9, 5'd8);
    idle(5'd8, 5'd9, 5'd8);
    cyc(1'b1, 5'd8, 32'h0000_0001, 1'b0, 5'd0, 5'd8, 5'd9, 5'd8);
    idle(5'd8, 5'd9, 5'd8);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd8, 5'd9);
    idle(5'd9, 5'd10, 5'd9);
    cyc(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd10, 5'd9, 5'd10, 5'd9);
    idle(5'd9, 5'd10, 5'd9);
    cyc(1'b1, 5'd10, 32'h0000_0077, 1'b1, 5'd10, 5'd10, 5'd9, 5'd10);
    idle(5'd10, 5'd9, 5'd10);

    // Asynchronous reset mid-cycle with a write and a reservation pending.
    @(negedge clk);
    rd_addr = {5'd10, 5'd4}; dbg_addr = 5'd4;
    WE = 1'b1; write_reg_number = 5'd12; write_data = 32'h5555_6666;
    rsv_en = 1'b1; rsv_reg = 5'd13;
    #2 rst_n = 1'b0;
    #1;
    chk("rst a0", {32'd0, a0}, 64'd0);
    chk("rst rd_data", rd_data, 64'd0);
    chk("rst rd_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst busy_count", {58'd0, busy_count}, 64'd0);
    chk("rst dbg_data", {32'd0, dbg_data}, 64'd0);
    model_reset();
    @(posedge clk);
    #2;
    WE = 1'b0; rsv_en = 1'b0;
    rst_n = 1'b1;
    idle(5'd12, 5'd13, 5'd12);

    // Randomised traffic, addresses biased to collide.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, rr, ra0, ra1;
      wr  = 5'($urandom_range(0, 15));
      rr  = 5'($urandom_range(0, 15));
      ra0 = ($urandom_range(0, 1) == 0) ? wr : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 1) == 0) ? rr : 5'($urandom_range(0, 31));
      cyc(1'($urandom_range(0, 1)), wr, $urandom, 1'($urandom_range(0, 2) == 0), rr,
          ra0, ra1, 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, 0 required", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
